// File: rtl/rans_freq_loader_if.sv
// AXI-lite write-only bus between the rANS table loader (master) and the encoder control slave.
interface rans_freq_loader_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/rans_freq_loader.sv
// Streams per-symbol frequencies into the rANS encoder table over AXI-lite, then writes restart.
// Optional RANS_LOADER_SUM_CHECK_EN: skip the restart write and flag an error if the table total is wrong.
module rans_freq_loader #(
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = SYMBOL_WIDTH + 1,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  freq_valid_i,
  output logic                  freq_ready_o,
  input  logic [RESOLUTION-1:0] freq_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  rans_freq_loader_if.master    axi
);

  localparam int unsigned SYM_W    = SYMBOL_WIDTH + 1;
  localparam int unsigned CUM_W    = RESOLUTION + 1;
  localparam int unsigned SUM_W    = RESOLUTION + 2;
  localparam int unsigned LAST_SYM = 2**SYMBOL_WIDTH - 1;
  localparam int unsigned RST_ADDR = 2**SYMBOL_WIDTH;
  localparam int unsigned TOTAL    = 2**RESOLUTION;
  localparam int unsigned SAT      = TOTAL + 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, WRITE, RESP, RESTART, RESTART_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [SYM_W-1:0]      sym_q, sym_d;
  logic [CUM_W-1:0]      cum_q, cum_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic [SUM_W-1:0]      cum_sum_c;
  logic                  sum_bad_c;

  assign cum_sum_c = SUM_W'(cum_q) + SUM_W'(freq_i);

`ifdef RANS_LOADER_SUM_CHECK_EN
  // Sticky saturation marker for the running total
  logic ovf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == FETCH && freq_valid_i && cum_sum_c > SUM_W'(SAT)) begin
      ovf_q <= 1'b1;
    end
  end

  assign sum_bad_c = ovf_q || (cum_q != CUM_W'(TOTAL));
`else
  assign sum_bad_c = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sym_q     <= '0;
      cum_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_q     <= sym_d;
      cum_q     <= cum_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    cum_d     = cum_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    error_d   = error_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sym_d   = '0;
          cum_d   = '0;
          error_d = 1'b0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (freq_valid_i) begin
          awaddr_d  = ADDR_WIDTH'(sym_q);
          wdata_d   = DATA_WIDTH'({freq_i, cum_q[RESOLUTION-1:0]});
          cum_d     = (cum_sum_c > SUM_W'(SAT)) ? CUM_W'(SAT) : CUM_W'(cum_sum_c);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WRITE;
        end
      end

      // AW and W retire independently; advance once both are gone
      WRITE, RESTART: begin
        if (awvalid_q && axi.m_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.m_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d = (state_q == WRITE) ? RESP : RESTART_RESP;
        end
      end

      RESP: begin
        if (axi.m_bvalid) begin
          if (axi.m_bresp != 2'b00) error_d = 1'b1;
          sym_d = sym_q + SYM_W'(1);
          if (sym_q != SYM_W'(LAST_SYM)) begin
            state_d = FETCH;
          end else if (sum_bad_c) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            awaddr_d  = ADDR_WIDTH'(RST_ADDR);
            wdata_d   = '0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = RESTART;
          end
        end
      end

      RESTART_RESP: begin
        if (axi.m_bvalid) begin
          if (axi.m_bresp != 2'b00) error_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign freq_ready_o  = (state_q == FETCH);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign axi.m_awaddr  = awaddr_q;
  assign axi.m_awvalid = awvalid_q;
  assign axi.m_wdata   = wdata_q;
  assign axi.m_wstrb   = '1;
  assign axi.m_wvalid  = wvalid_q;
  assign axi.m_bready  = (state_q == RESP) || (state_q == RESTART_RESP);

endmodule

// File: tb/tb_rans_freq_loader.sv
// Directed bench for rans_freq_loader: AXI-lite slave model plus an address/data scoreboard.
module tb_rans_freq_loader;

  localparam int unsigned R    = 10;
  localparam int unsigned S    = 8;
  localparam int unsigned AW   = S + 1;
  localparam int unsigned DW   = 32;
  localparam int          NSYM = 256;
`ifdef RANS_LOADER_SUM_CHECK_EN
  localparam bit SUM_CHECK = 1'b1;
`else
  localparam bit SUM_CHECK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         fvalid;
  logic [R-1:0] freq;
  logic         fready, busy, done, err;

  always #5 clk = ~clk;

  rans_freq_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rans_freq_loader #(
    .RESOLUTION(R), .SYMBOL_WIDTH(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .freq_valid_i(fvalid), .freq_ready_o(fready), .freq_i(freq),
    .busy_o(busy), .done_o(done), .error_o(err),
    .axi(bus.master)
  );

  int total = 0;
  int bad   = 0;

  int            aw_hs, w_hs, b_hs;
  logic [AW-1:0] last_addr;
  int            aw_stall = 0;
  int            err_addr = -1;
  int            aw_wait;
  logic          prev_aw_pend, prev_w_hs;
  logic [AW-1:0] prev_awaddr;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard and checks AW/W channel discipline
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_hs = 0; w_hs = 0; b_hs = 0;
      prev_aw_pend = 1'b0; prev_w_hs = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
    end else begin
      if (prev_aw_pend && bus.m_awvalid)
        check("awaddr_stable", 32'(bus.m_awaddr), 32'(prev_awaddr));
      if (prev_w_hs)
        check("wvalid_drop", 32'(bus.m_wvalid), 32'(0));
      prev_aw_pend = bus.m_awvalid && !bus.m_awready;
      prev_awaddr  = bus.m_awaddr;
      prev_w_hs    = bus.m_wvalid && bus.m_wready;
      if (bus.m_awvalid && bus.m_awready) begin
        aw_hs++;
        last_addr = bus.m_awaddr;
        if (exp_addr_q.size() == 0) check("aw_unexpected", 32'(0), 32'(1));
        else check("awaddr", 32'(bus.m_awaddr), 32'(exp_addr_q.pop_front()));
      end
      if (bus.m_wvalid && bus.m_wready) begin
        w_hs++;
        if (exp_data_q.size() == 0) check("w_unexpected", 32'(0), 32'(1));
        else check("wdata", bus.m_wdata, exp_data_q.pop_front());
        check("wstrb", 32'(bus.m_wstrb), 32'hF);
      end
      if (bus.m_bvalid && bus.m_bready) b_hs++;
    end
  end

  // Slave responder: optional AW stall, immediate W, B one cycle after both land
  always @(negedge clk) begin
    if (rst) begin
      bus.m_awready = 1'b0; bus.m_wready = 1'b0;
      bus.m_bvalid  = 1'b0; bus.m_bresp  = 2'b00;
      aw_wait = 0;
    end else begin
      if (bus.m_awvalid && aw_hs == b_hs) begin
        if (aw_wait >= aw_stall) bus.m_awready = 1'b1;
        else begin bus.m_awready = 1'b0; aw_wait++; end
      end else begin
        bus.m_awready = 1'b0; aw_wait = 0;
      end
      bus.m_wready = bus.m_wvalid && (w_hs == b_hs);
      bus.m_bvalid = (aw_hs > b_hs) && (w_hs > b_hs);
      bus.m_bresp  = (bus.m_bvalid && int'(last_addr) == err_addr) ? 2'b10 : 2'b00;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
    check("err_cleared", 32'(err), 32'(0));
    check("fready_in_fetch", 32'(fready), 32'(1));
  endtask

  task automatic feed(input int f, input int n);
    int cum = 0;
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      fvalid = 1'b1;
      freq   = R'(f);
      while (!fready && waited < 50) begin @(negedge clk); waited++; end
      if (!fready) begin
        check("fready_timeout", 32'(0), 32'(1));
        fvalid = 1'b0;
        return;
      end
      if (err_addr >= 0 && k == err_addr)     check("err_before_bad_resp", 32'(err), 32'(0));
      if (err_addr >= 0 && k == err_addr + 1) check("err_after_bad_resp", 32'(err), 32'(1));
      exp_addr_q.push_back(AW'(k));
      exp_data_q.push_back(DW'((f << R) | (cum & ((1 << R) - 1))));
      cum = cum + f;
      if (cum > (1 << R) + 1) cum = (1 << R) + 1;
      @(negedge clk);
    end
    fvalid = 1'b0;
  endtask

  task automatic finish_load(input bit restart, input bit exp_err, input int exp_b,
                             input int b0, input bit poke_start);
    int waited = 0;
    if (restart) begin
      exp_addr_q.push_back(AW'(NSYM));
      exp_data_q.push_back('0);
    end
    if (poke_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (!done && waited < 200) begin @(negedge clk); waited++; end
    check("done_pulse", 32'(done), 32'(1));
    check("busy_at_done", 32'(busy), 32'(0));
    check("error_at_done", 32'(err), 32'(exp_err));
    check("b_count", 32'(b_hs - b0), 32'(exp_b));
    check("aw_leftover", 32'(exp_addr_q.size()), 32'(0));
    check("w_leftover", 32'(exp_data_q.size()), 32'(0));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'(0));
  endtask

  initial begin
    int b0;
    rst = 1'b1; start = 1'b0; fvalid = 1'b0; freq = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_fready", 32'(fready), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_error", 32'(err), 32'(0));
    check("rst_awvalid", 32'(bus.m_awvalid), 32'(0));
    check("rst_wvalid", 32'(bus.m_wvalid), 32'(0));
    check("rst_bready", 32'(bus.m_bready), 32'(0));
    check("rst_awaddr", 32'(bus.m_awaddr), 32'(0));
    check("rst_wdata", bus.m_wdata, 32'(0));
    rst = 1'b0;

    // Uniform table, zero-wait slave, stray start mid-load
    b0 = b_hs; do_start(); feed(4, NSYM);
    finish_load(1'b1, 1'b0, NSYM + 1, b0, 1'b1);

    // AW held off three cycles while W is accepted at once
    aw_stall = 3;
    b0 = b_hs; do_start(); feed(4, NSYM);
    finish_load(1'b1, 1'b0, NSYM + 1, b0, 1'b0);
    aw_stall = 0;

    // Slave error on symbol 17 only
    err_addr = 17;
    b0 = b_hs; do_start(); feed(4, NSYM);
    finish_load(1'b1, 1'b1, NSYM + 1, b0, 1'b0);
    err_addr = -1;

    // Short table (768); the start also clears the sticky error
    b0 = b_hs; do_start(); feed(3, NSYM);
    finish_load(!SUM_CHECK, SUM_CHECK, SUM_CHECK ? NSYM : NSYM + 1, b0, 1'b0);

    // Oversized table: running sum saturates at 1025
    b0 = b_hs; do_start(); feed(8, NSYM);
    finish_load(!SUM_CHECK, SUM_CHECK, SUM_CHECK ? NSYM : NSYM + 1, b0, 1'b0);

    // Reset while symbol 40 is pending on AW
    aw_stall = 3;
    do_start(); feed(4, 41);
    check("awvalid_before_rst", 32'(bus.m_awvalid), 32'(1));
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_fready", 32'(fready), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_error", 32'(err), 32'(0));
    check("arst_awvalid", 32'(bus.m_awvalid), 32'(0));
    check("arst_wvalid", 32'(bus.m_wvalid), 32'(0));
    check("arst_bready", 32'(bus.m_bready), 32'(0));
    check("arst_awaddr", 32'(bus.m_awaddr), 32'(0));
    check("arst_wdata", bus.m_wdata, 32'(0));
    @(negedge clk);
    rst = 1'b0;
    aw_stall = 0;
    b0 = b_hs; do_start(); feed(4, NSYM);
    finish_load(1'b1, 1'b0, NSYM + 1, b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
